// File: rtl/iobuf_host_loader.sv
// iobuf_host_loader: loads host words into the input IOBuf, kicks the accelerator, drains the output IOBuf to the host
module iobuf_host_loader #(
    parameter int DWIDTH  = 32,
    parameter int ADWIDTH = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Cfg_Start,
    input  logic [ADWIDTH-1:0] Cfg_Load_Len,
    input  logic [ADWIDTH-1:0] Cfg_Store_Len,
    output logic               Busy,
    output logic               Done,
    input  logic [DWIDTH-1:0]  S_Data,
    input  logic               S_Valid,
    output logic               S_Ready,
    output logic [DWIDTH-1:0]  M_Data,
    output logic               M_Valid,
    input  logic               M_Ready,
    output logic               Host_Own,
    output logic [ADWIDTH-1:0] Buf0_Addr,
    output logic               Buf0_Wea,
    output logic [DWIDTH-1:0]  Buf0_Wdata,
    output logic [ADWIDTH-1:0] Buf1_Addr,
    input  logic [DWIDTH-1:0]  Buf1_Rdata,
    output logic               Accel_Start,
    input  logic               Accel_Done
);
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_WAIT, ST_DRAIN, ST_DONE} state_t;
    state_t state, state_nx;
    logic [ADWIDTH:0] load_len, store_len, ld_cnt, rd_cnt, out_cnt;
    logic [DWIDTH-1:0] fifo [2];
    logic wr_ptr, rd_ptr, rd_pend;
    logic [1:0] fifo_cnt;
    logic [2:0] occ_next;
    logic beat, pop, issue, last_beat, last_word;
    assign beat      = state == ST_LOAD && S_Valid;
    assign pop       = fifo_cnt != 2'd0 && M_Ready;
    assign occ_next  = {1'b0, fifo_cnt} + {2'b0, rd_pend} - {2'b0, pop};
    assign issue     = state == ST_DRAIN && rd_cnt != store_len && occ_next <= 3'd1;
    assign last_beat = beat && ld_cnt + 1'b1 == load_len;
    assign last_word = pop && out_cnt + 1'b1 == store_len;
    // state register
    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nx;
    end
    // next-state decode; Cfg_Start and Accel_Done only matter in IDLE and WAIT
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (Cfg_Start) state_nx = Cfg_Load_Len == '0 ? ST_START : ST_LOAD;
            ST_LOAD:  if (last_beat) state_nx = ST_START;
            ST_START: state_nx = ST_WAIT;
            ST_WAIT:  if (Accel_Done) state_nx = store_len == '0 ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (last_word) state_nx = ST_DONE;
            default:  state_nx = ST_IDLE;
        endcase
    end
    // outputs; unused addresses and write data are forced to 0
    always_comb begin
        Busy        = state != ST_IDLE;
        Done        = state == ST_DONE;
        S_Ready     = state == ST_LOAD;
        Accel_Start = state == ST_START;
        Host_Own    = !(state == ST_START || state == ST_WAIT);
        Buf0_Wea    = beat;
        Buf0_Addr   = beat ? ld_cnt[ADWIDTH-1:0] : '0;
        Buf0_Wdata  = beat ? S_Data : '0;
        Buf1_Addr   = issue ? rd_cnt[ADWIDTH-1:0] : '0;
        M_Valid     = fifo_cnt != 2'd0;
        M_Data      = fifo[rd_ptr];
    end
    // counters, length latches and the 2-entry output FIFO fed by one-cycle-latency reads
    always_ff @(posedge Clk) begin
        if (Reset) begin
            load_len  <= '0;
            store_len <= '0;
            ld_cnt    <= '0;
            rd_cnt    <= '0;
            out_cnt   <= '0;
            rd_pend   <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
            fifo[0]   <= '0;
            fifo[1]   <= '0;
        end else begin
            if (state == ST_IDLE && Cfg_Start) begin
                load_len  <= {1'b0, Cfg_Load_Len};
                store_len <= {1'b0, Cfg_Store_Len};
                ld_cnt    <= '0;
                rd_cnt    <= '0;
                out_cnt   <= '0;
            end
            if (beat) ld_cnt <= ld_cnt + 1'b1;
            if (issue) rd_cnt <= rd_cnt + 1'b1;
            rd_pend <= issue;
            if (rd_pend) begin
                fifo[wr_ptr] <= Buf1_Rdata;
                wr_ptr       <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= !rd_ptr;
                out_cnt <= out_cnt + 1'b1;
            end
            fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_iobuf_host_loader.sv
// tb_iobuf_host_loader: table-driven batches with per-cycle protocol checks and a reset-mid-drain sequence
module tb_iobuf_host_loader;
    localparam int DW = 32;
    localparam int AW = 4;
    logic          Clk = 1'b0, Reset = 1'b1, Cfg_Start = 1'b0;
    logic [AW-1:0] Cfg_Load_Len = '0, Cfg_Store_Len = '0;
    logic          Busy, Done, S_Ready, M_Valid, Host_Own, Buf0_Wea, Accel_Start;
    logic [DW-1:0] S_Data = '0, M_Data, Buf0_Wdata, Buf1_Rdata = '0;
    logic          S_Valid = 1'b0, M_Ready = 1'b0, Accel_Done = 1'b0;
    logic [AW-1:0] Buf0_Addr, Buf1_Addr;
    int tests = 0, fails = 0;

    typedef struct {
        int ld; int st; int dly; bit bp; bit spur; int rst_after; int exp_cyc;
    } vec_t;
    vec_t tab [9];

    iobuf_host_loader #(.DWIDTH(DW), .ADWIDTH(AW)) dut (
        .Clk(Clk), .Reset(Reset), .Cfg_Start(Cfg_Start), .Cfg_Load_Len(Cfg_Load_Len),
        .Cfg_Store_Len(Cfg_Store_Len), .Busy(Busy), .Done(Done), .S_Data(S_Data),
        .S_Valid(S_Valid), .S_Ready(S_Ready), .M_Data(M_Data), .M_Valid(M_Valid),
        .M_Ready(M_Ready), .Host_Own(Host_Own), .Buf0_Addr(Buf0_Addr), .Buf0_Wea(Buf0_Wea),
        .Buf0_Wdata(Buf0_Wdata), .Buf1_Addr(Buf1_Addr), .Buf1_Rdata(Buf1_Rdata),
        .Accel_Start(Accel_Start), .Accel_Done(Accel_Done)
    );

    always #5 Clk = ~Clk;

    // output IOBuf model: word at address a is 0xA0+a, registered read
    always @(posedge Clk) Buf1_Rdata <= 32'hA0 + 32'(Buf1_Addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_ctl"}, {Busy, Done, S_Ready, M_Valid, Buf0_Wea, Accel_Start, Host_Own}, 7'b0000001);
        chk({name, "_dat"}, {Buf0_Addr, Buf1_Addr, M_Data}, '0);
    endtask

    task automatic idle_inputs();
        Cfg_Start = 1'b0; S_Valid = 1'b0; M_Ready = 1'b0; Accel_Done = 1'b0;
    endtask

    task automatic run(input vec_t v);
        int c = 1, sent = 0, got = 0, starts = 0, dones = 0, st_c = 0, acc_at = -1, done_c = 0;
        bit aborted = 1'b0, prev_stall = 1'b0;
        logic [DW-1:0] prev_d = '0;
        Cfg_Load_Len = AW'(v.ld);
        Cfg_Store_Len = AW'(v.st);
        Cfg_Start = 1'b1;
        @(posedge Clk); #1;
        while (c < 300 && dones == 0 && !aborted) begin
            S_Valid = sent < v.ld && (!v.bp || $urandom_range(0, 1) == 1);
            S_Data = 32'h11 * (sent + 1);
            M_Ready = !v.bp || c % 4 == 3;
            Accel_Done = c == acc_at || (v.spur && c == 2);
            Cfg_Start = v.spur && st_c > 0 && c == st_c + 2;
            Cfg_Load_Len = Cfg_Start ? AW'(9) : AW'(v.ld);
            Cfg_Store_Len = Cfg_Start ? AW'(9) : AW'(v.st);
            #1;
            chk("s_ready_extra", S_Ready && sent >= v.ld, 0);
            if (S_Valid && S_Ready) begin
                chk("wr_en", Buf0_Wea, 1);
                chk("wr_addr", Buf0_Addr, sent);
                chk("wr_data", Buf0_Wdata, 32'h11 * (sent + 1));
                sent++;
            end else chk("wr_idle", Buf0_Wea, 0);
            if (Accel_Start) begin
                starts++;
                st_c = c;
                acc_at = c + v.dly;
            end
            chk("host_own", Host_Own, !(st_c > 0 && c <= acc_at));
            chk("rd_bound", Buf1_Addr > got + 2, 0);
            if (prev_stall) chk("m_hold", {M_Valid, M_Data}, {1'b1, prev_d});
            chk("m_extra", M_Valid && got >= v.st, 0);
            prev_stall = M_Valid && !M_Ready;
            prev_d = M_Data;
            if (M_Valid && M_Ready) begin
                chk("m_data", M_Data, 32'hA0 + got);
                got++;
            end
            if (Done) begin
                dones++;
                done_c = c;
            end else begin
                @(posedge Clk); #1;
                c++;
                aborted = v.rst_after > 0 && got == v.rst_after;
            end
        end
        idle_inputs();
        if (aborted) begin
            Reset = 1'b1;
            @(posedge Clk); #1;
            chk_reset("rst_mid");
            chk("no_done", dones, 0);
            Reset = 1'b0;
            @(posedge Clk); #1;
        end else begin
            chk("done_seen", dones, 1);
            chk("sent", sent, v.ld);
            chk("got", got, v.st);
            chk("starts", starts, 1);
            if (!v.bp) chk("start_cyc", st_c, v.ld + 1);
            if (v.exp_cyc > 0) chk("done_cyc", done_c, v.exp_cyc);
            @(posedge Clk); #1;
            chk("idle_after", {Busy, Done}, 2'b00);
        end
    endtask

    initial begin
        tab[0] = '{4, 4, 10, 1'b0, 1'b0, 0, 22};
        tab[1] = '{6, 7, 4, 1'b1, 1'b0, 0, 0};
        tab[2] = '{0, 0, 3, 1'b0, 1'b0, 0, 5};
        tab[3] = '{3, 3, 5, 1'b0, 1'b1, 0, 15};
        tab[4] = '{2, 5, 2, 1'b0, 1'b0, 2, 0};
        tab[5] = '{2, 3, 2, 1'b0, 1'b0, 0, 11};
        tab[6] = '{15, 15, 2, 1'b0, 1'b0, 0, 36};
        tab[7] = '{3, 0, 1, 1'b0, 1'b0, 0, 6};
        tab[8] = '{0, 2, 1, 1'b0, 1'b0, 0, 7};
        repeat (3) @(posedge Clk);
        #1;
        chk_reset("reset");
        Reset = 1'b0;
        @(posedge Clk); #1;
        chk("idle_busy", Busy, 0);
        for (int i = 0; i < 9; i++) run(tab[i]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
